// File: rtl/axis_exp_adc_seq_if.sv
// Stream handshake bundle for the 32-bit register-command path.
// The master drives data/valid and the slave returns ready.
interface axis_exp_adc_seq_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_exp_adc_seq.sv
// Acquisition sequencer for the SPI ADC: periodic triggers, sample counting,
// and a one-entry command register gated so commands never overlap acquisitions.
module axis_exp_adc_seq #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_num_samples,
  input  logic                 start,
  input  logic                 stop,
  output logic                 adc_trigger,
  input  logic                 adc_csn,
  input  logic                 adc_tvalid,
  input  logic                 adc_tready,
  axis_exp_adc_seq_if.slave    s_cmd,
  axis_exp_adc_seq_if.master   m_cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 reg_mode,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] overrun_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] clamp_period(input logic [CNT_WIDTH-1:0] p);
    return (p < TWO) ? TWO : p;
  endfunction

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_num;
  logic [CNT_WIDTH-1:0] r_pcnt;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_samples;
  logic [CNT_WIDTH-1:0] r_overrun;
  logic                 r_trig;
  logic                 r_done;
  logic                 r_reg_mode;
  logic                 r_cmd_full;
  logic [31:0]          r_cmd_data;

  logic w_start_ok;
  logic w_s_hs;
  logic w_m_hs;
  logic w_sample;
  logic w_can_fire;
  logic w_tick;
  logic w_run_end;
  logic w_s_ready;

  assign w_start_ok = (r_state == IDLE) && start && !r_reg_mode && !r_cmd_full;
  // A start accepted this cycle wins over a command, so no command can slip into a run.
  assign w_s_ready  = (r_state == IDLE) && !r_cmd_full && !w_start_ok;
  assign w_s_hs     = s_cmd.tvalid && w_s_ready;
  assign w_m_hs     = r_cmd_full && m_cmd.tready;
  assign w_sample   = adc_tvalid && adc_tready;
  assign w_can_fire = adc_csn && !r_trig;
  assign w_tick     = (r_pcnt == r_period - ONE);
  assign w_run_end  = stop || ((r_num != '0) && (r_issued == r_num));

  // The first tick is resolved on the start edge so the trigger lands the next cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_period  <= '0;
      r_num     <= '0;
      r_pcnt    <= '0;
      r_issued  <= '0;
      r_samples <= '0;
      r_overrun <= '0;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state   <= RUN;
            r_period  <= clamp_period(cfg_period);
            r_num     <= cfg_num_samples;
            r_pcnt    <= '0;
            r_samples <= '0;
            r_trig    <= adc_csn;
            r_issued  <= adc_csn ? ONE : '0;
            r_overrun <= adc_csn ? '0 : ONE;
          end
        end
        RUN: begin
          if (w_sample) r_samples <= sat_inc(r_samples);
          if (w_run_end) begin
            r_state <= DRAIN;
          end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + ONE;
            if (w_tick) begin
              if (w_can_fire) begin
                r_trig   <= 1'b1;
                r_issued <= r_issued + ONE;
              end else begin
                r_overrun <= sat_inc(r_overrun);
              end
            end
          end
        end
        DRAIN: begin
          if (w_sample) r_samples <= sat_inc(r_samples);
          if (r_samples == r_issued) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Register-mode tracking follows the command as it leaves towards the ADC.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cmd_full <= 1'b0;
      r_cmd_data <= '0;
      r_reg_mode <= 1'b0;
    end else if (w_s_hs) begin
      r_cmd_full <= 1'b1;
      r_cmd_data <= s_cmd.tdata;
    end else if (w_m_hs) begin
      r_cmd_full <= 1'b0;
      if (r_cmd_data[23:21] == 3'b101) begin
        r_reg_mode <= 1'b1;
      end else if (r_cmd_data[23:0] == 24'h801401) begin
        r_reg_mode <= 1'b0;
      end
    end
  end

  assign adc_trigger   = r_trig;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign reg_mode      = r_reg_mode;
  assign sample_count  = r_samples;
  assign overrun_count = r_overrun;
  assign s_cmd.tready  = w_s_ready;
  assign m_cmd.tvalid  = r_cmd_full;
  assign m_cmd.tdata   = r_cmd_data;

endmodule

// File: tb/tb_axis_exp_adc_seq.sv
// Directed bench for axis_exp_adc_seq with a behavioural ADC that stays busy
// for ten cycles after each trigger and then returns one sample.
module tb_axis_exp_adc_seq;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_num_samples = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          adc_trigger;
  logic          adc_csn;
  logic          adc_tvalid;
  logic          adc_tready;
  logic          busy, done, reg_mode;
  logic [CW-1:0] sample_count, overrun_count;

  axis_exp_adc_seq_if s_if ();
  axis_exp_adc_seq_if m_if ();

  int checks = 0;
  int errors = 0;

  axis_exp_adc_seq #(.CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_period(cfg_period), .cfg_num_samples(cfg_num_samples),
    .start(start), .stop(stop),
    .adc_trigger(adc_trigger), .adc_csn(adc_csn),
    .adc_tvalid(adc_tvalid), .adc_tready(adc_tready),
    .s_cmd(s_if), .m_cmd(m_if),
    .busy(busy), .done(done), .reg_mode(reg_mode),
    .sample_count(sample_count), .overrun_count(overrun_count)
  );

  always #5 aclk = ~aclk;

  assign adc_tready = 1'b1;

  // ADC model: busy ten cycles after a trigger, then one sample beat.
  int adc_cnt;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      adc_cnt    <= 0;
      adc_csn    <= 1'b1;
      adc_tvalid <= 1'b0;
    end else begin
      adc_tvalid <= 1'b0;
      if (adc_trigger) begin
        adc_cnt <= 10;
        adc_csn <= 1'b0;
      end else if (adc_cnt != 0) begin
        adc_cnt <= adc_cnt - 1;
        if (adc_cnt == 1) begin
          adc_csn    <= 1'b1;
          adc_tvalid <= 1'b1;
        end
      end
    end
  end

  // Event monitor: trigger times, done pulses, accepted-start time.
  int            cyc = 0;
  int            trig_cnt = 0;
  int            done_cnt = 0;
  int            out_run = 0;
  int            start_t = 0;
  int            trig_t [64];
  logic [CW-1:0] done_samp = '0;
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (adc_trigger) begin
      if (trig_cnt < 64) trig_t[trig_cnt] <= cyc;
      trig_cnt <= trig_cnt + 1;
      if (!busy) out_run <= out_run + 1;
    end
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_samp <= sample_count;
    end
    if (start && !busy) start_t <= cyc;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int maxc);
    int n = 0;
    while (done_cnt == base && n < maxc) begin
      @(negedge aclk);
      n++;
    end
    chk("done_within_budget", longint'(done_cnt != base), 1);
  endtask

  task automatic send_cmd(input logic [31:0] data, input int maxc);
    int n = 0;
    @(negedge aclk);
    s_if.tdata  = data;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && n < maxc) begin
      @(negedge aclk);
      n++;
    end
    chk("cmd_accept_within_budget", longint'(s_if.tready), 1);
    @(negedge aclk) s_if.tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int bt, bd, n;
  logic [31:0] held;

  initial begin
    s_if.tdata  = 32'h00A0_0000;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    start       = 1'b1;

    // Reset held with start and command valid asserted.
    repeat (3) @(negedge aclk);
    chk("rst_trigger", adc_trigger, 0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reg_mode", reg_mode, 0);
    chk("rst_samples", sample_count, 0);
    chk("rst_overrun", overrun_count, 0);
    start       = 1'b0;
    s_if.tvalid = 1'b0;
    aresetn     = 1'b1;
    @(negedge aclk);
    chk("post_rst_s_tready", s_if.tready, 1);
    chk("post_rst_busy", busy, 0);

    // Timed acquisition: period 40, five samples.
    cfg_period = 40; cfg_num_samples = 5;
    bt = trig_cnt; bd = done_cnt;
    pulse_start();
    wait_done(bd, 400);
    repeat (5) @(negedge aclk);
    chk("timed_triggers", trig_cnt - bt, 5);
    chk("timed_first_latency", trig_t[bt] - start_t, 1);
    for (int i = 1; i < 5; i++) chk("timed_interval", trig_t[bt+i] - trig_t[bt+i-1], 40);
    chk("timed_samples", sample_count, 5);
    chk("timed_done_samples", done_samp, 5);
    chk("timed_overrun", overrun_count, 0);
    chk("timed_done_pulses", done_cnt - bd, 1);
    chk("timed_busy_after", busy, 0);

    // Overrun: period 4, three samples, ADC busy ten cycles per conversion.
    cfg_period = 4; cfg_num_samples = 3;
    bt = trig_cnt; bd = done_cnt;
    pulse_start();
    wait_done(bd, 200);
    repeat (5) @(negedge aclk);
    chk("ovr_triggers", trig_cnt - bt, 3);
    chk("ovr_interval1", trig_t[bt+1] - trig_t[bt], 12);
    chk("ovr_interval2", trig_t[bt+2] - trig_t[bt+1], 12);
    chk("ovr_overrun", overrun_count, 4);
    chk("ovr_samples", sample_count, 3);
    chk("ovr_done_samples", done_samp, 3);
    chk("ovr_done_pulses", done_cnt - bd, 1);

    // Continuous mode stopped two cycles after the first trigger.
    cfg_period = 20; cfg_num_samples = 0;
    bt = trig_cnt; bd = done_cnt;
    pulse_start();
    n = 0;
    while (trig_cnt == bt && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("cont_first_trigger_seen", longint'(trig_cnt != bt), 1);
    @(negedge aclk) stop = 1'b1;
    @(negedge aclk) stop = 1'b0;
    repeat (3) @(negedge aclk);
    chk("cont_drain_busy", busy, 1);
    chk("cont_no_early_done", done_cnt - bd, 0);
    wait_done(bd, 100);
    repeat (60) @(negedge aclk);
    chk("cont_triggers", trig_cnt - bt, 1);
    chk("cont_done_pulses", done_cnt - bd, 1);
    chk("cont_done_samples", done_samp, 1);
    chk("cont_samples", sample_count, 1);

    // Command gating: command offered during a run is held off until done.
    cfg_period = 10; cfg_num_samples = 2;
    bd = done_cnt;
    pulse_start();
    m_if.tready = 1'b0;
    s_if.tdata  = 32'h0012_3456;
    s_if.tvalid = 1'b1;
    @(negedge aclk);
    chk("gate_busy", busy, 1);
    chk("gate_s_tready_run", s_if.tready, 0);
    chk("gate_m_tvalid_run", m_if.tvalid, 0);
    wait_done(bd, 200);
    s_if.tvalid = 1'b0;
    chk("gate_m_tvalid", m_if.tvalid, 1);
    chk("gate_m_tdata", m_if.tdata, 32'h0012_3456);
    chk("gate_s_tready_full", s_if.tready, 0);
    held = m_if.tdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("gate_hold_tvalid", m_if.tvalid, 1);
      chk("gate_hold_tdata", m_if.tdata, held);
    end
    m_if.tready = 1'b1;
    @(negedge aclk);
    chk("gate_m_tvalid_after", m_if.tvalid, 0);
    chk("gate_reg_mode", reg_mode, 0);
    chk("gate_s_tready_empty", s_if.tready, 1);

    // Register mode blocks starts until the exit command.
    send_cmd(32'h00A0_0000, 20);
    @(negedge aclk);
    chk("reg_mode_set", reg_mode, 1);
    cfg_period = 10; cfg_num_samples = 1;
    bt = trig_cnt;
    pulse_start();
    repeat (15) @(negedge aclk);
    chk("reg_start_ignored_trig", trig_cnt - bt, 0);
    chk("reg_start_ignored_busy", busy, 0);
    send_cmd(32'h0080_1401, 20);
    @(negedge aclk);
    chk("reg_mode_clear", reg_mode, 0);
    bt = trig_cnt; bd = done_cnt;
    pulse_start();
    wait_done(bd, 100);
    chk("reg_second_start_trig", trig_cnt - bt, 1);
    chk("reg_second_start_latency", trig_t[bt] - start_t, 1);
    chk("trigger_outside_run", out_run, 0);

    // Asynchronous reset in the middle of a continuous run.
    cfg_period = 8; cfg_num_samples = 0;
    pulse_start();
    repeat (4) @(negedge aclk);
    chk("midrst_busy_before", busy, 1);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_trigger", adc_trigger, 0);
    chk("midrst_samples", sample_count, 0);
    @(negedge aclk) aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_s_tready", s_if.tready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
